// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared register-file definitions for the write-back merge block.
//   RegAddrLen / reg_addr_bus_t : register address width and type (RegAddrBus)
//   RegWidth / reg_bus_t        : register data width and type (RegBus)
//   RegNum                      : number of architectural registers
//   ZeroWord, RstEnable, True   : common constants
//   ld_entry_t                  : one buffered load response {addr, data}
package regfile_wb_pkg;

    localparam int unsigned RegAddrLen = 5;
    localparam int unsigned RegNum     = 32;
    localparam int unsigned RegWidth   = 32;

    typedef logic [RegAddrLen-1:0] reg_addr_bus_t;
    typedef logic [RegWidth-1:0]   reg_bus_t;

    localparam reg_bus_t ZeroWord  = '0;
    localparam logic     RstEnable = 1'b1;
    localparam logic     True      = 1'b1;

    typedef struct packed {
        reg_addr_bus_t addr;
        reg_bus_t      data;
    } ld_entry_t;

    localparam int unsigned LdEntryW = $bits(ld_entry_t);

    // x0 is hard-wired zero: writes to it are dropped and it is never busy.
    function automatic logic is_x0(input reg_addr_bus_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: generic DEPTH x WIDTH synchronous FIFO, async active-high reset.
//   clk_i, rst_i  : clock, asynchronous reset (active high)
//   push_i        : write wdata_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : current head entry (valid when !empty_o)
//   full_o/empty_o: status, derived from registered pointers only
module wb_ld_fifo
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RstEnable) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + (AW + 1)'(1);
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: merges in-order pipeline results and out-of-band load responses onto the
// single register-file write port, and tracks pending loads per register for decode.
//   clk_i, rst_i                 : clock, asynchronous reset (active high)
//   ex_wreq_i/ex_waddr_i/ex_wdata_i : pipeline result (never back-pressured, top priority)
//   ld_issue_i/ld_issue_addr_i   : load dispatched to memory; bumps its register's counter
//   ld_valid_i/ld_ready_o        : load response handshake (ready = FIFO not full)
//   ld_waddr_i/ld_wdata_i        : load response destination and data
//   w_req_o/w_addr_o/w_data_o    : registered regfile write port
//   q1/q2_addr_i, q1/q2_busy_o   : decode scoreboard queries (combinational)
// Build option REGFILE_WB_LD_BYPASS_EN: a load accepted while the FIFO is empty and no ex
// write is present is written on its acceptance edge instead of being buffered.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ex_wreq_i,
    input  reg_addr_bus_t ex_waddr_i,
    input  reg_bus_t      ex_wdata_i,
    input  logic          ld_issue_i,
    input  reg_addr_bus_t ld_issue_addr_i,
    input  logic          ld_valid_i,
    output logic          ld_ready_o,
    input  reg_addr_bus_t ld_waddr_i,
    input  reg_bus_t      ld_wdata_i,
    output logic          w_req_o,
    output reg_addr_bus_t w_addr_o,
    output reg_bus_t      w_data_o,
    input  reg_addr_bus_t q1_addr_i,
    input  reg_addr_bus_t q2_addr_i,
    output logic          q1_busy_o,
    output logic          q2_busy_o
);

    logic                w_req_q, w_req_d;
    reg_addr_bus_t       w_addr_q, w_addr_d;
    reg_bus_t            w_data_q, w_data_d;
    logic [CNT_W-1:0]    cnt_q [RegNum];
    logic [CNT_W-1:0]    cnt_d [RegNum];

    logic                ex_ok, accept, pop, push, bypass;
    logic                fifo_full, fifo_empty;
    logic [LdEntryW-1:0] fifo_rdata;
    ld_entry_t           head, ld_in;
    logic                dec_en, inc_en;
    reg_addr_bus_t       dec_addr;

    assign ld_ready_o = ~fifo_full;
    assign head       = ld_entry_t'(fifo_rdata);
    assign ld_in      = '{addr: ld_waddr_i, data: ld_wdata_i};

    always_comb begin
        ex_ok  = (ex_wreq_i == True) && !is_x0(ex_waddr_i);
        accept = ld_valid_i && ld_ready_o;
        // An ex write to x0 is a no-op, so it must not steal the port from the FIFO.
        pop    = !ex_ok && !fifo_empty;
`ifdef REGFILE_WB_LD_BYPASS_EN
        bypass = accept && fifo_empty && !ex_ok;
`else
        bypass = 1'b0;
`endif
        push   = accept && !bypass;
    end

    wb_ld_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LdEntryW)
    ) u_ld_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (ld_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output mux: ex > FIFO head > (bypassed load) > idle. Idle and x0-load cycles hold
    // the address/data so the regfile port does not toggle needlessly.
    always_comb begin
        w_req_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        dec_en   = 1'b0;
        dec_addr = head.addr;
        if (ex_ok) begin
            w_req_d  = 1'b1;
            w_addr_d = ex_waddr_i;
            w_data_d = ex_wdata_i;
        end else if (pop) begin
            dec_en = 1'b1;
            if (!is_x0(head.addr)) begin
                w_req_d  = 1'b1;
                w_addr_d = head.addr;
                w_data_d = head.data;
            end
        end else if (bypass) begin
            dec_en   = 1'b1;
            dec_addr = ld_waddr_i;
            if (!is_x0(ld_waddr_i)) begin
                w_req_d  = 1'b1;
                w_addr_d = ld_waddr_i;
                w_data_d = ld_wdata_i;
            end
        end
    end

    // Pending-load counters; x0 is never incremented or decremented so it stays at zero.
    always_comb begin
        inc_en = ld_issue_i && !is_x0(ld_issue_addr_i);
        for (int unsigned r = 0; r < RegNum; r++) begin
            logic inc, dec;
            inc      = inc_en && (ld_issue_addr_i == reg_addr_bus_t'(r));
            dec      = dec_en && !is_x0(dec_addr) && (dec_addr == reg_addr_bus_t'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RstEnable) begin
            w_req_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= ZeroWord;
            for (int unsigned r = 0; r < RegNum; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            w_req_q  <= w_req_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            for (int unsigned r = 0; r < RegNum; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign w_req_o  = w_req_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

    assign q1_busy_o = !is_x0(q1_addr_i) && (cnt_q[q1_addr_i] != '0);
    assign q2_busy_o = !is_x0(q2_addr_i) && (cnt_q[q2_addr_i] != '0);

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-side companion to the register file. Merges two result streams into the single regfile write port (`w_req`/`w_addr`/`w_data`):
  - in-order pipeline results from MEM;
  - out-of-band load responses from the memory controller.
- Buffers load responses in a small FIFO and keeps a per-register pending-load scoreboard, which decode queries to stall on load-use.

Parameters:
- DEPTH, 2, load-response FIFO entries (power of two, ≥2)
- CNT_W, 2, width of each per-register pending-load counter

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active-high (`RstEnable`)
- ex_wreq  in  1  pipeline result valid (cannot be back-pressured)
- ex_waddr  in  `RegAddrBus`  pipeline destination register
- ex_wdata  in  `RegBus`  pipeline result
- ld_issue  in  1  load dispatched to memory this cycle
- ld_issue_addr  in  `RegAddrBus`  destination of dispatched load
- ld_valid  in  1  load response valid
- ld_ready  out  1  FIFO can accept (= not full)
- ld_waddr  in  `RegAddrBus`  load response destination
- ld_wdata  in  `RegBus`  load response data
- w_req  out  1  regfile write request (registered)
- w_addr  out  `RegAddrBus`  regfile write address (registered)
- w_data  out  `RegBus`  regfile write data (registered)
- q1_addr, q2_addr  in  `RegAddrBus`  decode scoreboard queries (rs1/rs2)
- q1_busy, q2_busy  out  1  queried register has a pending load (combinational)

Behaviour:
- Reset (async, while `rst` is high):
  - `w_req`=0, `w_addr`=0, `w_data`=`ZeroWord`.
  - FIFO emptied; all counters 0.
  - `ld_ready`=1 once reset deasserts.
  - Any in-flight load is forgotten. Responses arriving after reset must be squashed upstream.
- Load handshake: a load is accepted on a rising edge where `ld_valid && ld_ready`.
  - `ld_valid` may be held; the data must stay stable until accepted.
- Output register, updated every edge. Priority:
  1. `ex_wreq` with `ex_waddr`≠0: output the ex write.
  2. Otherwise, FIFO not empty: pop the head and output it.
  3. Otherwise: `w_req`=0; `w_addr`/`w_data` hold their last values.
- Latency:
  - ex: `w_req` is high for exactly the one cycle after `ex_wreq`.
  - load: earliest output is the edge after acceptance. A load accepted at edge N is driven at edge N+1 if no ex write occurs at N+1.
- Starvation: continuous ex writes starve the FIFO. The FIFO fills, `ld_ready` drops, and the memory controller stalls. This is legal.
- x0 handling:
  - `ex_wreq` to x0 produces no write. It does not block a FIFO pop that edge.
  - A load to x0 is accepted and discarded at pop. `w_req` stays 0 and a further entry may not pop that edge.
  - `ld_issue` to x0 does not touch the counters.
- Scoreboard:
  - `cnt[ld_issue_addr]` increments on `ld_issue`.
  - `cnt[r]` decrements at the edge where a load entry for r is popped (driven or discarded).
  - Increment and decrement of the same register on the same edge leave the count unchanged.
  - `qN_busy` = (`qN_addr`≠0) && (`cnt[qN_addr]`≠0).
  - In the cycle `w_req` shows the load, busy is already clear. Regfile forwarding supplies the value.
- Protocol obligations on the issuer:
  - never `ld_issue` to a register whose counter is at max;
  - never `ex_wreq` to a register with nonzero count (WAW);
  - decode stalls on busy rd.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- Simultaneous accept and pop in the same edge when full: not allowed. `ld_ready` depends only on the registered count.

Optional Feature:
- REGFILE_WB_LD_BYPASS_EN
- Defined: a load accepted at edge N, with the FIFO empty and no valid ex write at N, is driven at edge N itself (1-cycle load latency) and never enters the FIFO. Its counter decrements at N.
- Undefined: every load passes through the FIFO (minimum 2 cycles accept-to-`w_req`-visible).

Decomposition:
- Shared defines header holds `RegAddrBus`, `RegAddrLen`, `RegBus`, `RegNum`, `ZeroWord`, `RstEnable`, `True`.
- One sub-module is natural: wb_ld_fifo, a generic DEPTH×(`RegAddrLen`+32) synchronous FIFO with push/pop/full/empty and async reset.
- Scoreboard and output mux stay in regfile_wb.

Test Plan:
- ex priority:
  - stimulus: FIFO holds a load for x5 (data 0xAAAA0000); `ex_wreq` to x3 with 0x00000011 at the same edge;
  - required: the next cycle shows `w_addr`=3, `w_data`=0x11; the cycle after shows `w_addr`=5, `w_data`=0xAAAA0000.
- Load-use scoreboard:
  - stimulus: `ld_issue` x7; `q1_addr`=7;
  - required: `q1_busy`=1 until the cycle `w_req`=1, `w_addr`=7 appears, then 0; `q2_addr`=0 always gives busy 0.
- Back-pressure:
  - stimulus: `ex_wreq` every cycle, 3 loads presented with DEPTH=2;
  - required: `ld_ready`=0 after 2 accepts, the third load is held; after ex stops, 3 writes appear in order.
- x0 discard:
  - stimulus: load response to x0 (0xDEADBEEF), ex idle;
  - required: `w_req` never rises for it; the next queued load drains the following cycle.
- Reset mid-operation:
  - stimulus: FIFO with 2 entries, counters nonzero, assert `rst` asynchronously between edges;
  - required: `w_req`=0 immediately, busy outputs 0, `ld_ready`=1 after release, no stale writes.
- Bypass (macro defined):
  - stimulus: idle block, load x9 = 0x12345678 accepted at edge N;
  - required: `w_req`=1, `w_addr`=9 in the cycle following N; without the macro, one cycle later.
